// File: rtl/wb_regfile_pkg.sv
// Shared widths, types and the per-port read-select helper for the writeback register file.
package wb_regfile_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned CNT_W    = 32;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam data_t ZERO_WORD = DATA_W'(0);
    localparam addr_t NOP_ADDR  = ADDR_W'(0);

    // Read priority: reset, disabled port, $0, same-cycle writeback bypass, stored value.
    function automatic data_t rd_sel(
        input logic  rst,
        input logic  re,
        input addr_t raddr,
        input logic  we,
        input addr_t waddr,
        input data_t wdata,
        input data_t stored
    );
        data_t res;
        if (rst)                         res = ZERO_WORD;
        else if (!re)                    res = ZERO_WORD;
        else if (raddr == NOP_ADDR)      res = ZERO_WORD;
        else if (we && (waddr == raddr)) res = wdata;
        else                             res = stored;
        return res;
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB writeback and ID read-port bundle for wb_regfile.
// Optional HI/LO signals are present when WB_REGFILE_HILO_EN is defined.
interface wb_regfile_if;
    import wb_regfile_pkg::*;

    logic  we;
    addr_t waddr;
    data_t wdata;
    logic  re1;
    addr_t raddr1;
    data_t rdata1;
    logic  re2;
    addr_t raddr2;
    data_t rdata2;
    cnt_t  commit_cnt;
`ifdef WB_REGFILE_HILO_EN
    logic  whilo;
    data_t hi_i;
    data_t lo_i;
    data_t hi_o;
    data_t lo_o;
`endif

    modport master (
        output we, waddr, wdata, re1, raddr1, re2, raddr2,
        input  rdata1, rdata2, commit_cnt
`ifdef WB_REGFILE_HILO_EN
        , output whilo, hi_i, lo_i
        , input  hi_o, lo_o
`endif
    );

    modport slave (
        input  we, waddr, wdata, re1, raddr1, re2, raddr2,
        output rdata1, rdata2, commit_cnt
`ifdef WB_REGFILE_HILO_EN
        , input  whilo, hi_i, lo_i
        , output hi_o, lo_o
`endif
    );

endinterface

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO special-register pair with same-cycle write bypass.
// Only compiled when WB_REGFILE_HILO_EN is defined.
`ifdef WB_REGFILE_HILO_EN
module hilo_reg
    import wb_regfile_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  whilo,
    input  data_t hi_i,
    input  data_t lo_i,
    output data_t hi_o,
    output data_t lo_o
);

    data_t hi_q;
    data_t lo_q;

    // HI and LO always load together from the writeback stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= ZERO_WORD;
            lo_q <= ZERO_WORD;
        end else if (whilo) begin
            hi_q <= hi_i;
            lo_q <= lo_i;
        end
    end

    // Reads see the incoming pair while it is being written.
    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
        if (rst) begin
            hi_o = ZERO_WORD;
            lo_o = ZERO_WORD;
        end else if (whilo) begin
            hi_o = hi_i;
            lo_o = lo_i;
        end
    end

endmodule
`endif

// File: rtl/wb_regfile.sv
// Writeback-side GPR file for the 5-stage MIPS core: one write port, two
// combinational read ports with write bypass, and a debug commit counter.
// Define WB_REGFILE_HILO_EN to add the HI/LO register pair (hilo_reg).
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    data_t regs [NUM_REGS];
    cnt_t  cnt_q;

    // Commit non-$0 writebacks and count them; reset clears the whole array.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= ZERO_WORD;
            end
            cnt_q <= CNT_W'(0);
        end else if (bus.we && (bus.waddr != NOP_ADDR)) begin
            regs[bus.waddr] <= bus.wdata;
            cnt_q           <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.commit_cnt = cnt_q;

    // Read port 1 select.
    always_comb begin
        bus.rdata1 = ZERO_WORD;
        bus.rdata1 = rd_sel(rst, bus.re1, bus.raddr1, bus.we, bus.waddr, bus.wdata,
                            regs[bus.raddr1]);
    end

    // Read port 2 select.
    always_comb begin
        bus.rdata2 = ZERO_WORD;
        bus.rdata2 = rd_sel(rst, bus.re2, bus.raddr2, bus.we, bus.waddr, bus.wdata,
                            regs[bus.raddr2]);
    end

`ifdef WB_REGFILE_HILO_EN
    data_t hi_c;
    data_t lo_c;

    hilo_reg u_hilo (
        .clk   (clk),
        .rst   (rst),
        .whilo (bus.whilo),
        .hi_i  (bus.hi_i),
        .lo_i  (bus.lo_i),
        .hi_o  (hi_c),
        .lo_o  (lo_c)
    );

    assign bus.hi_o = hi_c;
    assign bus.lo_o = lo_c;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (HI/LO checks when WB_REGFILE_HILO_EN is defined).
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    wb_regfile_if bus ();

    wb_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock, then move 1 time unit past the edge before driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational reads settle after input changes.
    task automatic settle();
        #1;
    endtask

    task automatic idle_bus();
        bus.we     = 1'b0;
        bus.waddr  = '0;
        bus.wdata  = '0;
        bus.re1    = 1'b0;
        bus.raddr1 = '0;
        bus.re2    = 1'b0;
        bus.raddr2 = '0;
`ifdef WB_REGFILE_HILO_EN
        bus.whilo  = 1'b0;
        bus.hi_i   = '0;
        bus.lo_i   = '0;
`endif
    endtask

    task automatic wr(input addr_t a, input data_t d);
        bus.we    = 1'b1;
        bus.waddr = a;
        bus.wdata = d;
        tick();
        bus.we    = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_bus();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Reset: preload, then reset while reading the preloaded registers
        wr(5'd3, 32'h1111_1111);
        wr(5'd4, 32'h2222_2222);
        bus.re1 = 1'b1; bus.raddr1 = 5'd3;
        bus.re2 = 1'b1; bus.raddr2 = 5'd4;
        settle();
        check("preload_r3", bus.rdata1, 32'h1111_1111);
        check("preload_r4", bus.rdata2, 32'h2222_2222);
        check("preload_cnt", bus.commit_cnt, 32'd2);
        rst = 1'b1;
        settle();
        check("rst_rd1_forced0", bus.rdata1, 32'h0);
        check("rst_rd2_forced0", bus.rdata2, 32'h0);
        tick();
        rst = 1'b0;
        settle();
        check("post_rst_r3", bus.rdata1, 32'h0);
        check("post_rst_r4", bus.rdata2, 32'h0);
        check("post_rst_cnt", bus.commit_cnt, 32'd0);

        // Basic write then read on both ports
        idle_bus();
        wr(5'd5, 32'hDEAD_BEEF);
        bus.re1 = 1'b1; bus.raddr1 = 5'd5;
        bus.re2 = 1'b1; bus.raddr2 = 5'd5;
        settle();
        check("wr5_rd1", bus.rdata1, 32'hDEAD_BEEF);
        check("wr5_rd2", bus.rdata2, 32'hDEAD_BEEF);
        check("wr5_cnt", bus.commit_cnt, 32'd1);

        // Bypass: both ports see the in-flight write before the edge
        bus.raddr1 = 5'd7; bus.raddr2 = 5'd7;
        settle();
        check("r7_before_wr", bus.rdata1, 32'h0);
        bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h1234_5678;
        settle();
        check("byp_rd1", bus.rdata1, 32'h1234_5678);
        check("byp_rd2", bus.rdata2, 32'h1234_5678);
        check("byp_cnt_pre_edge", bus.commit_cnt, 32'd1);
        tick();
        bus.we = 1'b0;
        settle();
        check("r7_from_array", bus.rdata1, 32'h1234_5678);
        check("r7_cnt", bus.commit_cnt, 32'd2);

        // $0 guard: write discarded, read returns zero, count unchanged
        bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFF_FFFF;
        bus.re1 = 1'b1; bus.raddr1 = 5'd0;
        settle();
        check("r0_bypass_blocked", bus.rdata1, 32'h0);
        tick();
        bus.we = 1'b0;
        settle();
        check("r0_after_wr", bus.rdata1, 32'h0);
        check("r0_cnt", bus.commit_cnt, 32'd2);

        // Top register and read disable
        wr(5'd31, 32'hCAFE_F00D);
        bus.re1 = 1'b1; bus.raddr1 = 5'd31;
        bus.re2 = 1'b0; bus.raddr2 = 5'd5;
        settle();
        check("r31_rd1", bus.rdata1, 32'hCAFE_F00D);
        check("re2_off_rd2", bus.rdata2, 32'h0);
        check("r31_cnt", bus.commit_cnt, 32'd3);
        bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'h5555_AAAA;
        settle();
        check("re2_off_no_bypass", bus.rdata2, 32'h0);
        bus.we = 1'b0;

`ifdef WB_REGFILE_HILO_EN
        // HI/LO: bypass, stored value, and no effect on commit count
        settle();
        bus.whilo = 1'b1; bus.hi_i = 32'hA; bus.lo_i = 32'hB;
        settle();
        check("hi_bypass", bus.hi_o, 32'hA);
        check("lo_bypass", bus.lo_o, 32'hB);
        tick();
        bus.whilo = 1'b0; bus.hi_i = 32'h0; bus.lo_i = 32'h0;
        settle();
        check("hi_stored", bus.hi_o, 32'hA);
        check("lo_stored", bus.lo_o, 32'hB);
        check("hilo_cnt", bus.commit_cnt, 32'd3);
`endif

        // Reset collides with a write: reset wins
        bus.re1 = 1'b1; bus.raddr1 = 5'd9;
        bus.re2 = 1'b1; bus.raddr2 = 5'd5;
        rst = 1'b1;
        bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h9999_9999;
        settle();
        check("rst_we_rd1", bus.rdata1, 32'h0);
`ifdef WB_REGFILE_HILO_EN
        check("rst_hi", bus.hi_o, 32'h0);
`endif
        tick();
        rst = 1'b0;
        bus.we = 1'b0;
        settle();
        check("rst_we_r9", bus.rdata1, 32'h0);
        check("rst_we_r5", bus.rdata2, 32'h0);
        check("rst_we_cnt", bus.commit_cnt, 32'd0);
`ifdef WB_REGFILE_HILO_EN
        check("rst_lo_cleared", bus.lo_o, 32'h0);
`endif

        // First commit after reset counts from zero
        wr(5'd1, 32'h0000_0001);
        bus.raddr1 = 5'd1;
        settle();
        check("r1_after_rst", bus.rdata1, 32'h0000_0001);
        check("cnt_after_rst", bus.commit_cnt, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1);
    end

endmodule
